rf_packet_rx: RTL and testbench

- Parametrised pulse-position RF packet receiver. It converts a one-pulse-per-bit `rfin` stream into packets: a pulse inside the bit window decodes as 1, no pulse decodes as 0.
- It detects an all-ones preamble, then deserialises PACKET_SIZE data bits MSB first.
- The completed packet is presented on a valid/ack handshake for the SPI slave TOP to read out.
- Successor to the fixed 24-bit/0xFF receiver. Adds parametrised sizes, jitter tolerance with phase resync, a runtime external period, and overflow and glitch reporting.

---
 rtl/rf_rx_pkg.sv | 21 ++
 rtl/rf_edge_sync.sv | 32 +++
 rtl/rf_packet_rx.sv | 157 +++++++++++++++
 tb/tb_rf_packet_rx.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_rx_pkg.sv
// rf_rx_pkg: shared types and defaults for the RF pulse-position receiver.
// Holds the FSM state type, default sizing/timing and the TX preamble.
package rf_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_PACKET_SIZE   = 24;
  localparam int DEF_PREAMBLE_BITS = 8;
  localparam int DEF_PERIOD        = 10000;
  localparam int DEF_TOL           = 1000;
  localparam int DEF_CNT_W         = 16;

  // Preamble byte the transmitter sends ahead of the data bits.
  localparam logic [7:0] PREAMBLE = 8'hFF;

endpackage

// File: rtl/rf_edge_sync.sv
// rf_edge_sync: 2-flop synchroniser plus registered rising-edge detector.
// Ports: clk, rst (async active-low), i_rfin (async), o_edge (1-cycle pulse).
module rf_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rfin,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_edge;

  // o_edge rises 3 clocks after the rfin rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_rfin;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 & ~r_s3;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/rf_packet_rx.sv
// rf_packet_rx: pulse-position RF receiver; preamble detect, MSB-first
// deserialise, valid/ack output. Ports: clk, rst (async low), rfin,
// ext_period_en/ext_period (runtime period), pkt_ack, pkt_data, pkt_valid,
// pkt_rec (pulse), busy, overflow (sticky), err_glitch (pulse).
module rf_packet_rx
  import rf_rx_pkg::*;
#(
  parameter int PACKET_SIZE   = DEF_PACKET_SIZE,
  parameter int PREAMBLE_BITS = DEF_PREAMBLE_BITS,
  parameter int PERIOD        = DEF_PERIOD,
  parameter int TOL           = DEF_TOL,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rfin,
  input  logic                   ext_period_en,
  input  logic [CNT_W-1:0]       ext_period,
  input  logic                   pkt_ack,
  output logic [PACKET_SIZE-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   pkt_rec,
  output logic                   busy,
  output logic                   overflow,
  output logic                   err_glitch
);

  localparam int OW = $clog2(PREAMBLE_BITS + 1);
  localparam int BW = $clog2(PACKET_SIZE + 1);

  localparam logic [CNT_W:0]   L_TOL  = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]   L_MIN  = (CNT_W+1)'(2*TOL + 2);
  localparam logic [CNT_W-1:0] L_PER  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_TOUT = CNT_W'(TOL + 1);
  localparam logic [OW-1:0]    L_OLST = OW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0]    L_BLST = BW'(PACKET_SIZE - 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_per;
  logic [OW-1:0]          r_ones;
  logic [BW-1:0]          r_bitcnt;
  logic [PACKET_SIZE-1:0] r_shreg;
  logic [PACKET_SIZE-1:0] r_data;
  logic                   r_valid;
  logic                   r_ovf;
  logic                   r_glitch;

  logic                   w_edge;
  logic [CNT_W-1:0]       w_per_sel;
  logic [CNT_W:0]         w_cnt;
  logic [CNT_W:0]         w_lo;
  logic [CNT_W:0]         w_hi;
  logic                   w_early;
  logic                   w_hit;
  logic                   w_tout;

  rf_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rfin (rfin),
    .o_edge (w_edge)
  );

  // Too-short external periods would make the windows overlap.
  assign w_per_sel =
    (ext_period_en && ({1'b0, ext_period} >= L_MIN))
      ? ext_period : L_PER;

  // r_cnt counts cycles since the reference edge: the edge cycle is 0,
  // so an edge exactly one period later sees r_cnt == P.
  assign w_cnt   = {1'b0, r_cnt};
  assign w_lo    = {1'b0, r_per} - L_TOL;
  assign w_hi    = {1'b0, r_per} + L_TOL;
  assign w_early = w_edge && (w_cnt < w_lo);
  assign w_hit   = w_edge && !w_early && (w_cnt <= w_hi);
  // An edge in the timeout cycle wins, so timeout needs no edge.
  assign w_tout  = !w_edge && (w_cnt == w_hi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_per    <= '0;
      r_ones   <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_glitch <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      if (pkt_ack) r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_edge) begin
            r_state <= PRE;
            r_ones  <= OW'(1);
            r_cnt   <= L_ONE;
            r_per   <= w_per_sel;
          end
        end
        PRE: begin
          if (w_early) begin
            r_state  <= IDLE;
            r_glitch <= 1'b1;
          end else if (w_hit) begin
            r_cnt <= L_ONE;
            if (r_ones == L_OLST) begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end else begin
              r_ones <= r_ones + OW'(1);
            end
          end else if (w_tout) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        DATA: begin
          if (w_early) begin
            r_state  <= IDLE;
            r_glitch <= 1'b1;
          end else if (w_hit || w_tout) begin
            r_shreg  <= {r_shreg[PACKET_SIZE-2:0], w_hit};
            // Timeout keeps the nominal phase: it fires TOL past nominal.
            r_cnt    <= w_hit ? L_ONE : L_TOUT;
            r_bitcnt <= r_bitcnt + BW'(1);
            if (r_bitcnt == L_BLST) r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + L_ONE;
          end
        end
        DONE: begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
          if (r_valid && !pkt_ack) r_ovf <= 1'b1;
          r_state <= IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pkt_data   = r_data;
  assign pkt_valid  = r_valid;
  assign pkt_rec    = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign overflow   = r_ovf;
  assign err_glitch = r_glitch;

endmodule

// File: tb/tb_rf_packet_rx.sv
// tb_rf_packet_rx: directed bench for rf_packet_rx with P=20, TOL=4.
// Drives pulse trains and checks decoded packets and status outputs.
module tb_rf_packet_rx;

  localparam int P  = 20;
  localparam int T  = 4;
  localparam int N  = 24;
  localparam int PB = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rfin = 1'b0;
  logic          ext_period_en = 1'b0;
  logic [CW-1:0] ext_period = '0;
  logic          pkt_ack = 1'b0;
  logic [N-1:0]  pkt_data;
  logic          pkt_valid;
  logic          pkt_rec;
  logic          busy;
  logic          overflow;
  logic          err_glitch;

  int n_chk = 0;
  int n_err = 0;
  int n_rec = 0;
  int n_gl  = 0;
  int offs[32];

  always #5 clk = ~clk;

  rf_packet_rx #(
    .PACKET_SIZE   (N),
    .PREAMBLE_BITS (PB),
    .PERIOD        (P),
    .TOL           (T),
    .CNT_W         (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rfin          (rfin),
    .ext_period_en (ext_period_en),
    .ext_period    (ext_period),
    .pkt_ack       (pkt_ack),
    .pkt_data      (pkt_data),
    .pkt_valid     (pkt_valid),
    .pkt_rec       (pkt_rec),
    .busy          (busy),
    .overflow      (overflow),
    .err_glitch    (err_glitch)
  );

  always @(posedge clk) begin
    if (pkt_rec)    n_rec <= n_rec + 1;
    if (err_glitch) n_gl  <= n_gl + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse rises g clocks after the previous pulse rise.
  task automatic pulse_gap(input int g);
    repeat (g - 1) @(posedge clk);
    #1 rfin = 1'b1;
    @(posedge clk);
    #1 rfin = 1'b0;
  endtask

  // Preamble + data; a 1 bit lands k*per+offs[i] after the last pulse.
  task automatic send_frame(input logic [N-1:0] d,
                            input int per,
                            input int nsend);
    int  k;
    logic b;
    k = 0;
    for (int i = 0; i < PB + N && i < nsend; i++) begin
      b = (i < PB) ? 1'b1 : d[N-1-(i-PB)];
      k++;
      if (b) begin
        if (i == 0) pulse_gap(2);
        else pulse_gap(k * per + offs[i]);
        k = 0;
      end
    end
  endtask

  task automatic wait_rec(input string tag,
                          input int budget,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pkt_rec && n < budget);
    chk(tag, {31'd0, pkt_rec}, 32'd1);
  endtask

  task automatic ack();
    @(posedge clk);
    #1 pkt_ack = 1'b1;
    @(posedge clk);
    #1 pkt_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic clr_offs();
    foreach (offs[i]) offs[i] = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int r0;
    int g0;
    clr_offs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data",  {8'd0, pkt_data}, 32'd0);
    chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_rec",   {31'd0, pkt_rec}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ovf",   {31'd0, overflow}, 32'd0);
    chk("rst_gl",    {31'd0, err_glitch}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(5);

    // Clean frame at exact spacing
    r0 = n_rec;
    send_frame(24'hA5C30F, P, 32);
    wait_rec("clean_rec", 50, lat);
    chk("clean_lat", lat, 32'd4);
    @(negedge clk);
    chk("clean_data",  {8'd0, pkt_data}, 32'hA5C30F);
    chk("clean_valid", {31'd0, pkt_valid}, 32'd1);
    chk("clean_busy",  {31'd0, busy}, 32'd0);
    idle(5);
    chk("clean_npulse", n_rec - r0, 32'd1);
    ack();
    @(negedge clk);
    chk("ack_clr", {31'd0, pkt_valid}, 32'd0);
    ack();
    @(negedge clk);
    chk("ack_idle", {31'd0, pkt_valid}, 32'd0);
    idle(10);

    // Jitter within +/-TOL, including the extremes
    foreach (offs[i]) offs[i] = int'($urandom_range(8, 0)) - 4;
    offs[8]  = 4;
    offs[10] = -4;
    offs[13] = 4;
    offs[28] = -4;
    g0 = n_gl;
    send_frame(24'hA5C30F, P, 32);
    wait_rec("jit_rec", 60, lat);
    @(negedge clk);
    chk("jit_data", {8'd0, pkt_data}, 32'hA5C30F);
    chk("jit_nogl", n_gl - g0, 32'd0);
    ack();
    idle(10);

    // +5 on a 1 bit: times out, then the late edge glitches
    clr_offs();
    offs[8] = 5;
    g0 = n_gl;
    r0 = n_rec;
    send_frame(24'hA5C30F, P, 9);
    idle(10);
    chk("late_gl",   n_gl - g0, 32'd1);
    chk("late_busy", {31'd0, busy}, 32'd0);
    chk("late_norec", n_rec - r0, 32'd0);
    clr_offs();
    idle(40);

    // Early extra pulse in DATA
    g0 = n_gl;
    r0 = n_rec;
    send_frame(24'hA5C30F, P, 10);
    pulse_gap(6);
    idle(10);
    chk("gl_pulse", n_gl - g0, 32'd1);
    chk("gl_idle",  {31'd0, busy}, 32'd0);
    chk("gl_norec", n_rec - r0, 32'd0);
    idle(40);
    send_frame(24'h123456, P, 32);
    wait_rec("gl_next_rec", 80, lat);
    @(negedge clk);
    chk("gl_next_data", {8'd0, pkt_data}, 32'h123456);
    ack();
    idle(10);

    // Overflow: two frames without ack
    send_frame(24'h000001, P, 32);
    wait_rec("ovf_rec1", 80, lat);
    @(negedge clk);
    chk("ovf_first", {31'd0, overflow}, 32'd0);
    idle(10);
    send_frame(24'hFFFFFE, P, 32);
    wait_rec("ovf_rec2", 80, lat);
    @(negedge clk);
    chk("ovf_set",   {31'd0, overflow}, 32'd1);
    chk("ovf_data",  {8'd0, pkt_data}, 32'hFFFFFE);
    chk("ovf_valid", {31'd0, pkt_valid}, 32'd1);
    idle(10);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Same, with ack in the DONE cycle
    do_reset();
    @(negedge clk);
    chk("ovf_rst", {31'd0, overflow}, 32'd0);
    idle(5);
    send_frame(24'h000001, P, 32);
    wait_rec("ack_rec1", 80, lat);
    idle(10);
    send_frame(24'hFFFFFE, P, 32);
    wait_rec("ack_rec2", 80, lat);
    pkt_ack = 1'b1;
    @(posedge clk);
    #1 pkt_ack = 1'b0;
    @(negedge clk);
    chk("ackd_ovf",   {31'd0, overflow}, 32'd0);
    chk("ackd_valid", {31'd0, pkt_valid}, 32'd1);
    chk("ackd_data",  {8'd0, pkt_data}, 32'hFFFFFE);
    ack();
    idle(10);

    // External period 40
    ext_period_en = 1'b1;
    ext_period    = 16'd40;
    send_frame(24'hA5C30F, 40, 32);
    wait_rec("ext40_rec", 120, lat);
    @(negedge clk);
    chk("ext40_data", {8'd0, pkt_data}, 32'hA5C30F);
    ack();
    idle(10);

    // External period too small: falls back to PERIOD
    ext_period = 16'd9;
    send_frame(24'h5A3C96, P, 32);
    wait_rec("ext9_rec", 80, lat);
    @(negedge clk);
    chk("ext9_data", {8'd0, pkt_data}, 32'h5A3C96);
    ack();
    idle(10);

    // Toggling ext_period_en mid-frame is ignored
    ext_period_en = 1'b0;
    ext_period    = 16'd40;
    fork
      send_frame(24'hC3A50F, P, 32);
      begin
        repeat (150) @(posedge clk);
        #1 ext_period_en = 1'b1;
        repeat (200) @(posedge clk);
        #1 ext_period_en = 1'b0;
        repeat (100) @(posedge clk);
        #1 ext_period_en = 1'b1;
      end
    join
    wait_rec("tog_rec", 80, lat);
    @(negedge clk);
    chk("tog_data", {8'd0, pkt_data}, 32'hC3A50F);
    ext_period_en = 1'b0;
    idle(10);

    // Preamble abort: 5 ones then silence
    g0 = n_gl;
    send_frame(24'hA5C30F, P, 5);
    idle(6);
    chk("pre_busy", {31'd0, busy}, 32'd1);
    idle(40);
    chk("pre_idle", {31'd0, busy}, 32'd0);
    chk("pre_nogl", n_gl - g0, 32'd0);

    // Reset mid-DATA
    send_frame(24'h123456, P, 15);
    @(negedge clk);
    chk("mid_busy",  {31'd0, busy}, 32'd1);
    chk("mid_valid", {31'd0, pkt_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_data",  {8'd0, pkt_data}, 32'd0);
    chk("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_rec",   {31'd0, pkt_rec}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(40);
    r0 = n_rec;
    send_frame(24'h123456, P, 32);
    wait_rec("post_rec", 80, lat);
    @(negedge clk);
    chk("post_data", {8'd0, pkt_data}, 32'h123456);
    idle(5);
    chk("post_npulse", n_rec - r0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
